// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and register-file-side signals of the write-port arbiter.
// The arbiter uses the slave modport; the environment driving it uses the master modport.
interface regfile_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int ID_W = $clog2(NREQ);
  localparam int WE_W = 1 << ADDR_W;

  logic                     STALL;
  logic [NREQ-1:0]          REQ_VALID;
  logic [NREQ*ADDR_W-1:0]   REQ_ADDR;
  logic [NREQ*DATA_W-1:0]   REQ_DATA;
  logic [NREQ-1:0]          REQ_READY;
  logic [WE_W-1:0]          WE_ONEHOT;
  logic [DATA_W-1:0]        WR_DATA;
  logic                     WR_VALID;
  logic [ID_W-1:0]          GRANT_ID;

  modport slave (
    input  STALL, REQ_VALID, REQ_ADDR, REQ_DATA,
    output REQ_READY, WE_ONEHOT, WR_DATA, WR_VALID, GRANT_ID
  );

  modport master (
    output STALL, REQ_VALID, REQ_ADDR, REQ_DATA,
    input  REQ_READY, WE_ONEHOT, WR_DATA, WR_VALID, GRANT_ID
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters;
// the winning write is decoded to a one-hot write-enable and registered for one cycle.
module regfile_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  regfile_wr_arbiter_if.slave     bus
);
  localparam int ID_W = $clog2(NREQ);
  localparam int WE_W = 1 << ADDR_W;
  localparam logic [ID_W:0]   NREQ_EXT = (ID_W+1)'(NREQ);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NREQ - 1);

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.REQ_ADDR[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = bus.REQ_DATA[gi*DATA_W +: DATA_W];
  end

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [WE_W-1:0]   we_onehot_q, we_onehot_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_valid_q, wr_valid_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     cand;
  logic [NREQ-1:0]   req_ready;

  // Scan from the pointer with a wrapping index; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (!win_found && bus.REQ_VALID[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
    if (RESET || bus.STALL) begin
      win_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // A grant is always a transfer, since READY is only raised on a valid request.
  always_comb begin
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    we_onehot_d = '0;
    if (win_found) begin
      wr_valid_d                     = 1'b1;
      we_onehot_d[addr_arr[win_idx]] = 1'b1;
      wr_data_d                      = data_arr[win_idx];
      grant_id_d                     = win_idx;
      ptr_d                          = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q       <= '0;
      grant_id_q  <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      we_onehot_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      we_onehot_q <= we_onehot_d;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.WE_ONEHOT = we_onehot_q;
  assign bus.WR_DATA   = wr_data_q;
  assign bus.WR_VALID  = wr_valid_q;
  assign bus.GRANT_ID  = grant_id_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a
// round-robin reference model that tracks the pointer as a plain integer.
module tb_regfile_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [ADDR_W-1:0] s_addr [NREQ];
  logic [DATA_W-1:0] s_data [NREQ];

  always_comb begin
    bus.REQ_ADDR = '0;
    bus.REQ_DATA = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.REQ_ADDR[i*ADDR_W +: ADDR_W] = s_addr[i];
      bus.REQ_DATA[i*DATA_W +: DATA_W] = s_data[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit inv_en = 1'b0;

  // Reference model state
  int          m_ptr;
  logic [15:0] m_we;
  logic [31:0] m_data;
  logic        m_valid;
  int          m_gid;

  function automatic int m_winner();
    if (RESET || bus.STALL) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.REQ_VALID[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    int w;
    w = m_winner();
    return (w < 0) ? '0 : (NREQ'(1) << w);
  endfunction

  task automatic tick();
    int w;
    w = m_winner();
    @(posedge CLK);
    if (RESET) begin
      m_ptr = 0; m_we = '0; m_data = '0; m_valid = 1'b0; m_gid = 0;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_we    = 16'(1) << s_addr[w];
      m_data  = s_data[w];
      m_gid   = w;
      m_ptr   = (w + 1) % NREQ;
    end else begin
      m_valid = 1'b0;
      m_we    = '0;
    end
    #1;
  endtask

  always @(negedge CLK) begin
    if (inv_en) begin
      n_cmp++;
      if ($countones(bus.WE_ONEHOT) > 1 || ((bus.WE_ONEHOT != '0) !== bus.WR_VALID) ||
          $countones(bus.REQ_READY) > 1) begin
        n_err++;
        $display("FAIL invariant: we=%h wr_valid=%b ready=%b required onehot/consistent",
                 bus.WE_ONEHOT, bus.WR_VALID, bus.REQ_READY);
      end
    end
  end

  task automatic test_reset();
    RESET = 1'b1; bus.STALL = 1'b0; bus.REQ_VALID = '1;
    for (int i = 0; i < NREQ; i++) begin s_addr[i] = 4'(i); s_data[i] = 32'(i + 1); end
    m_ptr = 0; m_we = '0; m_data = '0; m_valid = 1'b0; m_gid = 0;
    tick();
    #1; n_cmp++;
    if (bus.REQ_READY !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b required 0000", bus.REQ_READY); end
    tick();
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h0 || bus.WR_VALID !== 1'b0 || bus.WR_DATA !== 32'h0 || bus.GRANT_ID !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%h v=%b d=%h g=%0d required 0/0/0/0",
               bus.WE_ONEHOT, bus.WR_VALID, bus.WR_DATA, bus.GRANT_ID);
    end
    bus.REQ_VALID = '0; RESET = 1'b0;
    $display("test_reset done");
    inv_en = 1'b1;
  endtask

  task automatic test_single();
    bus.REQ_VALID = 4'b0001; s_addr[0] = 4'h3; s_data[0] = 32'hDEADBEEF;
    #1; n_cmp++;
    if (bus.REQ_READY !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b required 0001", bus.REQ_READY); end
    tick();
    bus.REQ_VALID = '0;
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h0008 || bus.WR_DATA !== 32'hDEADBEEF || bus.GRANT_ID !== 2'd0 || bus.WR_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL single_write: got we=%h d=%h g=%0d v=%b required 0008/DEADBEEF/0/1",
               bus.WE_ONEHOT, bus.WR_DATA, bus.GRANT_ID, bus.WR_VALID);
    end
    tick();
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h0 || bus.WR_VALID !== 1'b0 || bus.WR_DATA !== 32'hDEADBEEF || bus.GRANT_ID !== 2'd0) begin
      n_err++;
      $display("FAIL single_idle_hold: got we=%h v=%b d=%h g=%0d required 0/0/DEADBEEF/0",
               bus.WE_ONEHOT, bus.WR_VALID, bus.WR_DATA, bus.GRANT_ID);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int i = 0; i < NREQ; i++) begin s_addr[i] = 4'($urandom); s_data[i] = $urandom; end
    bus.REQ_VALID = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      logic [15:0] exp_we;
      logic [31:0] exp_d;
      #1; n_cmp++;
      if (bus.REQ_READY !== (4'(1) << (c % 4))) begin
        n_err++; $display("FAIL burst_ready[%0d]: got %b required %b", c, bus.REQ_READY, 4'(1) << (c % 4));
      end
      exp_we = 16'(1) << s_addr[c % 4];
      exp_d  = s_data[c % 4];
      tick();
      n_cmp++;
      if (bus.GRANT_ID !== 2'(c % 4) || bus.WE_ONEHOT !== exp_we || bus.WR_DATA !== exp_d || bus.WE_ONEHOT == 16'h0) begin
        n_err++;
        $display("FAIL burst_grant[%0d]: got g=%0d we=%h d=%h required g=%0d we=%h d=%h",
                 c, bus.GRANT_ID, bus.WE_ONEHOT, bus.WR_DATA, c % 4, exp_we, exp_d);
      end
      s_addr[c % 4] = 4'($urandom); s_data[c % 4] = $urandom;
    end
    bus.REQ_VALID = '0;
    $display("test_back_to_back done");
  endtask

  task automatic test_same_addr();
    s_addr[1] = 4'hF; s_data[1] = 32'h11; s_addr[3] = 4'hF; s_data[3] = 32'h33;
    bus.REQ_VALID = 4'b1010;
    #1; n_cmp++;
    if (bus.REQ_READY !== 4'b0010) begin n_err++; $display("FAIL same_ready1: got %b required 0010", bus.REQ_READY); end
    tick();
    bus.REQ_VALID = 4'b1000;
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h8000 || bus.WR_DATA !== 32'h11 || bus.GRANT_ID !== 2'd1) begin
      n_err++; $display("FAIL same_first: got we=%h d=%h g=%0d required 8000/11/1", bus.WE_ONEHOT, bus.WR_DATA, bus.GRANT_ID);
    end
    tick();
    bus.REQ_VALID = '0;
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h8000 || bus.WR_DATA !== 32'h33 || bus.GRANT_ID !== 2'd3) begin
      n_err++; $display("FAIL same_second: got we=%h d=%h g=%0d required 8000/33/3", bus.WE_ONEHOT, bus.WR_DATA, bus.GRANT_ID);
    end
    $display("test_same_addr done");
  endtask

  task automatic test_stall();
    int j;
    int saved;
    j = $urandom_range(0, NREQ - 1);
    saved = (j + 1) % NREQ;
    bus.REQ_VALID = 4'(1) << j;
    tick();
    bus.REQ_VALID = 4'b1111; bus.STALL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; n_cmp++;
      if (bus.REQ_READY !== 4'b0000) begin n_err++; $display("FAIL stall_ready[%0d]: got %b required 0000", c, bus.REQ_READY); end
      tick();
      n_cmp++;
      if (bus.WE_ONEHOT !== 16'h0 || bus.WR_VALID !== 1'b0) begin
        n_err++; $display("FAIL stall_out[%0d]: got we=%h v=%b required 0/0", c, bus.WE_ONEHOT, bus.WR_VALID);
      end
    end
    bus.STALL = 1'b0;
    #1; n_cmp++;
    if (bus.REQ_READY !== (4'(1) << saved)) begin
      n_err++; $display("FAIL stall_resume_ready: got %b required %b", bus.REQ_READY, 4'(1) << saved);
    end
    tick();
    bus.REQ_VALID = '0;
    n_cmp++;
    if (bus.GRANT_ID !== 2'(saved) || bus.WR_VALID !== 1'b1) begin
      n_err++; $display("FAIL stall_resume_grant: got g=%0d v=%b required %0d/1", bus.GRANT_ID, bus.WR_VALID, saved);
    end
    $display("test_stall done (resume at %0d)", saved);
  endtask

  task automatic test_reset_mid();
    s_addr[2] = 4'h5; s_data[2] = $urandom;
    bus.REQ_VALID = 4'b0100;
    tick();
    RESET = 1'b1; bus.REQ_VALID = 4'b1111;
    #1; n_cmp++;
    if (bus.REQ_READY !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready: got %b required 0000", bus.REQ_READY); end
    tick();
    RESET = 1'b0;
    n_cmp++;
    if (bus.WE_ONEHOT !== 16'h0 || bus.WR_VALID !== 1'b0 || bus.GRANT_ID !== 2'd0) begin
      n_err++; $display("FAIL rstmid_out: got we=%h v=%b g=%0d required 0/0/0", bus.WE_ONEHOT, bus.WR_VALID, bus.GRANT_ID);
    end
    #1; n_cmp++;
    if (bus.REQ_READY !== 4'b0001) begin n_err++; $display("FAIL rstmid_first_ready: got %b required 0001", bus.REQ_READY); end
    tick();
    bus.REQ_VALID = '0;
    n_cmp++;
    if (bus.GRANT_ID !== 2'd0 || bus.WE_ONEHOT !== (16'(1) << s_addr[0])) begin
      n_err++; $display("FAIL rstmid_first_grant: got g=%0d we=%h required 0/%h", bus.GRANT_ID, bus.WE_ONEHOT, 16'(1) << s_addr[0]);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_addr_sweep();
    bus.REQ_VALID = 4'b0100;
    for (int a = 0; a < 16; a++) begin
      s_addr[2] = 4'(a); s_data[2] = $urandom;
      tick();
      n_cmp++;
      if (bus.WE_ONEHOT !== (16'(1) << a) || bus.GRANT_ID !== 2'd2 || bus.WR_DATA !== s_data[2]) begin
        n_err++; $display("FAIL sweep[%0d]: got we=%h g=%0d required %h/2", a, bus.WE_ONEHOT, bus.GRANT_ID, 16'(1) << a);
      end
    end
    bus.REQ_VALID = '0;
    $display("test_addr_sweep done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      logic [NREQ-1:0] rdy_exp;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.REQ_VALID[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.REQ_VALID[i] = 1'b1; s_addr[i] = 4'($urandom); s_data[i] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.REQ_VALID[i] = 1'b0;
        end
      end
      bus.STALL = ($urandom_range(0, 7) == 0);
      RESET     = ($urandom_range(0, 49) == 0);
      #1;
      rdy_exp = m_ready();
      n_cmp++;
      if (bus.REQ_READY !== rdy_exp) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b required %b", c, bus.REQ_READY, rdy_exp);
      end
      tick();
      n_cmp++;
      if (bus.WE_ONEHOT !== m_we || bus.WR_DATA !== m_data || bus.WR_VALID !== m_valid || bus.GRANT_ID !== 2'(m_gid)) begin
        n_err++;
        $display("FAIL rand_out[%0d]: got we=%h d=%h v=%b g=%0d required we=%h d=%h v=%b g=%0d",
                 c, bus.WE_ONEHOT, bus.WR_DATA, bus.WR_VALID, bus.GRANT_ID, m_we, m_data, m_valid, m_gid);
      end
      bus.REQ_VALID = bus.REQ_VALID & ~rdy_exp;
    end
    RESET = 1'b0; bus.STALL = 1'b0; bus.REQ_VALID = '0;
    $display("test_random done");
  endtask

  initial begin
    RESET = 1'b1;
    bus.STALL = 1'b0;
    bus.REQ_VALID = '0;
    for (int i = 0; i < NREQ; i++) begin s_addr[i] = '0; s_data[i] = '0; end
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_same_addr();
    test_stall();
    test_reset_mid();
    test_addr_sweep();
    test_random();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
